// File: rtl/param_array_fifo.sv
// param_array_fifo: DEPTH-entry circular word buffer with a registered output stage and a wrapping accepted-word counter.
// Optional feature macro GT_CKSUM_EN adds an XOR checksum of accepted words on output `cksum`.
module param_array_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       cnt
`ifdef GT_CKSUM_EN
    ,
    output logic [WIDTH-1:0]       cksum
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] acnt_q, acnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef GT_CKSUM_EN
    logic [WIDTH-1:0] cksum_q, cksum_d;
`endif

    logic push;
    logic load;
    logic stage_free;

    // in_ready depends only on registered occupancy so a producer never sees a path from out_ready.
    assign in_ready   = (acnt_q != LVL_W'(DEPTH));
    assign push       = in_valid & in_ready;
    assign stage_free = ~out_valid_q | out_ready;
    assign load       = (acnt_q != '0) & stage_free;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        acnt_d      = acnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
`ifdef GT_CKSUM_EN
        cksum_d     = cksum_q;
`endif

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            cnt_d    = cnt_q + CNT_W'(1);
`ifdef GT_CKSUM_EN
            cksum_d  = cksum_q ^ in;
`endif
        end

        // A word always passes through mem; the stage never bypasses from the write port.
        if (load) begin
            out_d       = mem_q[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            out_valid_d = 1'b1;
        end else if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
        end

        case ({push, load})
            2'b10:   acnt_d = acnt_q + LVL_W'(1);
            2'b01:   acnt_d = acnt_q - LVL_W'(1);
            default: acnt_d = acnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            acnt_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
`ifdef GT_CKSUM_EN
            cksum_q     <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            acnt_q      <= acnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
`ifdef GT_CKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

    // Storage array is deliberately not reset; pointers and occupancy alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign cnt       = cnt_q;
    assign level     = acnt_q + {{PTR_W{1'b0}}, out_valid_q};
`ifdef GT_CKSUM_EN
    assign cksum     = cksum_q;
`endif

endmodule
